// File: rtl/rob_mc.sv
`default_nettype none
// ============================================================================
// Module   : rob_mc
// Purpose  : Parametrised reorder buffer with NUM_CDB write-back channels,
//            per-entry completion kind (normal/branch/store/jalr), valid/ready
//            issue handshake, operand lookup with CDB bypass, in-order commit.
//            Tag 0 means "no producer"; live tags cycle through 1..DEPTH-1.
// Options  : `define ROB_DUAL_COMMIT_EN to retire two adjacent normal entries
//            per cycle on write ports 0 and 1.
// Revision : 1.0  initial release
// ============================================================================
module rob_mc #(
  parameter int DEPTH       = 16,
  parameter int NUM_CDB     = 2,
  parameter int FULL_MARGIN = 4,
  parameter int OPT_W       = 6,
  parameter int IDX_W       = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy_i,
  input  logic                     iss_valid_i,
  output logic                     iss_ready_o,
  output logic [IDX_W-1:0]         iss_idx_o,
  input  logic [1:0]               iss_kind_i,
  input  logic                     iss_done_i,
  input  logic [OPT_W-1:0]         iss_opt_i,
  input  logic [4:0]               iss_dest_i,
  input  logic [31:0]              iss_data_i,
  input  logic [31:0]              iss_cur_pc_i,
  input  logic [31:0]              iss_mis_pc_i,
  input  logic                     iss_pb_tk_i,
  input  logic [IDX_W-1:0]         src1_idx_i,
  input  logic [IDX_W-1:0]         src2_idx_i,
  output logic                     src1_rdy_o,
  output logic                     src2_rdy_o,
  output logic [31:0]              src1_val_o,
  output logic [31:0]              src2_val_o,
  input  logic [NUM_CDB-1:0]       cdb_valid_i,
  input  logic [NUM_CDB*IDX_W-1:0] cdb_src_i,
  input  logic [NUM_CDB*32-1:0]    cdb_val_i,
  input  logic [NUM_CDB-1:0]       cdb_tk_i,
  output logic                     st_commit_req_o,
  input  logic                     st_commit_ack_i,
  output logic                     reg_wr0_ena_o,
  output logic [4:0]               reg_wr0_rd_o,
  output logic [31:0]              reg_wr0_val_o,
  output logic [IDX_W-1:0]         reg_wr0_idx_o,
  output logic                     reg_wr1_ena_o,
  output logic [4:0]               reg_wr1_rd_o,
  output logic [31:0]              reg_wr1_val_o,
  output logic [IDX_W-1:0]         reg_wr1_idx_o,
  output logic                     bp_fb_ena_o,
  output logic                     bp_fb_tk_o,
  output logic [31:0]              bp_fb_pc_o,
  output logic                     rb_ena_o,
  output logic [31:0]              rb_pc_o,
  output logic [OPT_W-1:0]         dbg_head_opt_o   // opcode tag of the head entry
);

  localparam int             CNT_W       = IDX_W + 1;
  localparam logic [CNT_W-1:0] ISS_LIMIT = CNT_W'(DEPTH - 1 - FULL_MARGIN);
  localparam logic [1:0]     KIND_NORMAL = 2'd0;
  localparam logic [1:0]     KIND_BRANCH = 2'd1;
  localparam logic [1:0]     KIND_STORE  = 2'd2;
  localparam logic [1:0]     KIND_JALR   = 2'd3;

  // Tag successor; skips the reserved tag 0 on wrap.
  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? IDX_W'(1) : i + IDX_W'(1);
  endfunction

  logic             valid_q  [DEPTH];
  logic             busy_q   [DEPTH];
  logic [1:0]       kind_q   [DEPTH];
  logic [OPT_W-1:0] opt_q    [DEPTH];
  logic [4:0]       dest_q   [DEPTH];
  logic [31:0]      data_q   [DEPTH];
  logic [31:0]      cur_pc_q [DEPTH];
  logic [31:0]      mis_pc_q [DEPTH];
  logic             pb_tk_q  [DEPTH];
  logic             tk_q     [DEPTH];

  logic [IDX_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             reg_wr0_ena_q, reg_wr1_ena_q, bp_fb_ena_q, bp_fb_tk_q, rb_ena_q;
  logic [4:0]       reg_wr0_rd_q, reg_wr1_rd_q;
  logic [31:0]      reg_wr0_val_q, reg_wr1_val_q, bp_fb_pc_q, rb_pc_q;
  logic [IDX_W-1:0] reg_wr0_idx_q, reg_wr1_idx_q;

  logic iss_fire, st_req, pop0, pop1, same_rd;

  assign iss_ready_o = rdy_i && !rb_ena_q && (count_q < ISS_LIMIT);
  assign iss_fire    = iss_valid_i && iss_ready_o;
  assign iss_idx_o   = tail_q;

`ifdef ROB_DUAL_COMMIT_EN
  logic [IDX_W-1:0] head1;
  assign head1 = nxt(head_q);
`endif

  // Commit decision for the head (and, in dual mode, head+1). Nothing retires
  // while a flush is pending so a store behind a mispredict never reaches memory.
  always_comb begin
    st_req  = rdy_i && !rb_ena_q && valid_q[head_q] && (kind_q[head_q] == KIND_STORE);
    pop0    = rdy_i && !rb_ena_q && valid_q[head_q] &&
              (((kind_q[head_q] != KIND_STORE) && !busy_q[head_q]) ||
               ((kind_q[head_q] == KIND_STORE) && st_commit_ack_i));
    pop1    = 1'b0;
    same_rd = 1'b0;
`ifdef ROB_DUAL_COMMIT_EN
    pop1    = pop0 && (kind_q[head_q] == KIND_NORMAL) && valid_q[head1] &&
              !busy_q[head1] && (kind_q[head1] == KIND_NORMAL);
    same_rd = pop1 && (dest_q[head_q] == dest_q[head1]);
`endif
  end

  logic [1:0][IDX_W-1:0] src_idx;
  logic [1:0]            src_rdy;
  logic [1:0][31:0]      src_val;
  assign src_idx = {src2_idx_i, src1_idx_i};

  // Operand lookup: stored value, overridden by the highest matching CDB channel.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_rdy[s] = valid_q[src_idx[s]] && !busy_q[src_idx[s]];
      src_val[s] = data_q[src_idx[s]];
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_valid_i[k] && valid_q[src_idx[s]] &&
            (cdb_src_i[k*IDX_W +: IDX_W] == src_idx[s])) begin
          src_rdy[s] = 1'b1;
          src_val[s] = cdb_val_i[k*32 +: 32];
        end
      end
      if (src_idx[s] == '0) begin
        src_rdy[s] = 1'b1;
        src_val[s] = 32'd0;
      end
    end
  end

  assign src1_rdy_o = src_rdy[0];
  assign src2_rdy_o = src_rdy[1];
  assign src1_val_o = src_val[0];
  assign src2_val_o = src_val[1];

  // Entry state, pointers, occupancy and registered commit/flush outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q        <= IDX_W'(1);
      tail_q        <= IDX_W'(1);
      count_q       <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e] <= 1'b0;
        busy_q[e]  <= 1'b0;
      end
      reg_wr0_ena_q <= 1'b0;  reg_wr0_rd_q <= '0;  reg_wr0_val_q <= '0;  reg_wr0_idx_q <= '0;
      reg_wr1_ena_q <= 1'b0;  reg_wr1_rd_q <= '0;  reg_wr1_val_q <= '0;  reg_wr1_idx_q <= '0;
      bp_fb_ena_q   <= 1'b0;  bp_fb_tk_q   <= 1'b0; bp_fb_pc_q   <= '0;
      rb_ena_q      <= 1'b0;  rb_pc_q      <= '0;
    end else begin
      reg_wr0_ena_q <= 1'b0;
      reg_wr1_ena_q <= 1'b0;
      bp_fb_ena_q   <= 1'b0;
      rb_ena_q      <= 1'b0;
      if (rb_ena_q) begin
        for (int e = 0; e < DEPTH; e++) begin
          valid_q[e] <= 1'b0;
          busy_q[e]  <= 1'b0;
        end
        head_q  <= IDX_W'(1);
        tail_q  <= IDX_W'(1);
        count_q <= '0;
      end else if (rdy_i) begin
        // Later channels overwrite earlier ones on a shared tag.
        for (int k = 0; k < NUM_CDB; k++) begin
          if (cdb_valid_i[k] && valid_q[cdb_src_i[k*IDX_W +: IDX_W]]) begin
            data_q[cdb_src_i[k*IDX_W +: IDX_W]] <= cdb_val_i[k*32 +: 32];
            tk_q[cdb_src_i[k*IDX_W +: IDX_W]]   <= cdb_tk_i[k];
            busy_q[cdb_src_i[k*IDX_W +: IDX_W]] <= 1'b0;
          end
        end
        if (pop0) begin
          valid_q[head_q] <= 1'b0;
          case (kind_q[head_q])
            KIND_NORMAL: begin
              reg_wr0_ena_q <= (dest_q[head_q] != 5'd0) && !same_rd;
              reg_wr0_rd_q  <= dest_q[head_q];
              reg_wr0_val_q <= data_q[head_q];
              reg_wr0_idx_q <= head_q;
            end
            KIND_BRANCH: begin
              bp_fb_ena_q <= 1'b1;
              bp_fb_tk_q  <= tk_q[head_q];
              bp_fb_pc_q  <= cur_pc_q[head_q];
              if (tk_q[head_q] != pb_tk_q[head_q]) begin
                rb_ena_q <= 1'b1;
                rb_pc_q  <= mis_pc_q[head_q];
              end
            end
            KIND_JALR: begin
              reg_wr0_ena_q <= (dest_q[head_q] != 5'd0);
              reg_wr0_rd_q  <= dest_q[head_q];
              reg_wr0_val_q <= cur_pc_q[head_q] + 32'd4;
              reg_wr0_idx_q <= head_q;
              rb_ena_q      <= 1'b1;
              rb_pc_q       <= {data_q[head_q][31:1], 1'b0};
            end
            default: ;  // store: memory side already done, nothing to write back
          endcase
        end
`ifdef ROB_DUAL_COMMIT_EN
        if (pop1) begin
          valid_q[head1] <= 1'b0;
          reg_wr1_ena_q  <= (dest_q[head1] != 5'd0);
          reg_wr1_rd_q   <= dest_q[head1];
          reg_wr1_val_q  <= data_q[head1];
          reg_wr1_idx_q  <= head1;
        end
`endif
        if (iss_fire) begin
          valid_q[tail_q]  <= 1'b1;
          busy_q[tail_q]   <= !iss_done_i;
          kind_q[tail_q]   <= iss_kind_i;
          opt_q[tail_q]    <= iss_opt_i;
          dest_q[tail_q]   <= iss_dest_i;
          data_q[tail_q]   <= iss_data_i;
          cur_pc_q[tail_q] <= iss_cur_pc_i;
          mis_pc_q[tail_q] <= iss_mis_pc_i;
          pb_tk_q[tail_q]  <= iss_pb_tk_i;
          tk_q[tail_q]     <= 1'b0;
          tail_q           <= nxt(tail_q);
        end
        head_q  <= pop1 ? nxt(nxt(head_q)) : (pop0 ? nxt(head_q) : head_q);
        count_q <= count_q + {{IDX_W{1'b0}}, iss_fire}
                           - {{IDX_W{1'b0}}, pop0} - {{IDX_W{1'b0}}, pop1};
      end
    end
  end

  assign st_commit_req_o = st_req;
  assign reg_wr0_ena_o   = reg_wr0_ena_q;
  assign reg_wr0_rd_o    = reg_wr0_rd_q;
  assign reg_wr0_val_o   = reg_wr0_val_q;
  assign reg_wr0_idx_o   = reg_wr0_idx_q;
  assign reg_wr1_ena_o   = reg_wr1_ena_q;
  assign reg_wr1_rd_o    = reg_wr1_rd_q;
  assign reg_wr1_val_o   = reg_wr1_val_q;
  assign reg_wr1_idx_o   = reg_wr1_idx_q;
  assign bp_fb_ena_o     = bp_fb_ena_q;
  assign bp_fb_tk_o      = bp_fb_tk_q;
  assign bp_fb_pc_o      = bp_fb_pc_q;
  assign rb_ena_o        = rb_ena_q;
  assign rb_pc_o         = rb_pc_q;
  assign dbg_head_opt_o  = opt_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_rob_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_mc
// Purpose  : Directed self-checking bench for rob_mc (DEPTH=16, NUM_CDB=2).
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_rob_mc;
  localparam int IDX_W = 4;
  localparam int OPT_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rdy;
  logic              iss_valid, iss_ready, iss_done, iss_pb_tk;
  logic [IDX_W-1:0]  iss_idx, src1_idx, src2_idx;
  logic [1:0]        iss_kind;
  logic [OPT_W-1:0]  iss_opt, dbg_opt;
  logic [4:0]        iss_dest;
  logic [31:0]       iss_data, iss_cur_pc, iss_mis_pc;
  logic              src1_rdy, src2_rdy;
  logic [31:0]       src1_val, src2_val;
  logic [1:0]        cdb_valid, cdb_tk;
  logic [7:0]        cdb_src;
  logic [63:0]       cdb_val;
  logic              st_req, st_ack;
  logic              wr0_ena, wr1_ena, fb_ena, fb_tk, rb_ena;
  logic [4:0]        wr0_rd, wr1_rd;
  logic [31:0]       wr0_val, wr1_val, fb_pc, rb_pc;
  logic [IDX_W-1:0]  wr0_idx, wr1_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_mc dut (
    .clk(clk), .rst(rst), .rdy_i(rdy),
    .iss_valid_i(iss_valid), .iss_ready_o(iss_ready), .iss_idx_o(iss_idx),
    .iss_kind_i(iss_kind), .iss_done_i(iss_done), .iss_opt_i(iss_opt),
    .iss_dest_i(iss_dest), .iss_data_i(iss_data), .iss_cur_pc_i(iss_cur_pc),
    .iss_mis_pc_i(iss_mis_pc), .iss_pb_tk_i(iss_pb_tk),
    .src1_idx_i(src1_idx), .src2_idx_i(src2_idx),
    .src1_rdy_o(src1_rdy), .src2_rdy_o(src2_rdy),
    .src1_val_o(src1_val), .src2_val_o(src2_val),
    .cdb_valid_i(cdb_valid), .cdb_src_i(cdb_src), .cdb_val_i(cdb_val), .cdb_tk_i(cdb_tk),
    .st_commit_req_o(st_req), .st_commit_ack_i(st_ack),
    .reg_wr0_ena_o(wr0_ena), .reg_wr0_rd_o(wr0_rd), .reg_wr0_val_o(wr0_val), .reg_wr0_idx_o(wr0_idx),
    .reg_wr1_ena_o(wr1_ena), .reg_wr1_rd_o(wr1_rd), .reg_wr1_val_o(wr1_val), .reg_wr1_idx_o(wr1_idx),
    .bp_fb_ena_o(fb_ena), .bp_fb_tk_o(fb_tk), .bp_fb_pc_o(fb_pc),
    .rb_ena_o(rb_ena), .rb_pc_o(rb_pc), .dbg_head_opt_o(dbg_opt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr();
    rdy = 1'b1; iss_valid = 1'b0; iss_kind = 2'd0; iss_done = 1'b0; iss_opt = '0;
    iss_dest = '0; iss_data = '0; iss_cur_pc = '0; iss_mis_pc = '0; iss_pb_tk = 1'b0;
    src1_idx = '0; src2_idx = '0; cdb_valid = '0; cdb_src = '0; cdb_val = '0;
    cdb_tk = '0; st_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic issue(input logic [1:0] kind, input logic done, input logic [4:0] dest,
                       input logic [31:0] data, input logic [31:0] cpc,
                       input logic [31:0] mpc, input logic pbtk);
    iss_valid = 1'b1; iss_kind = kind; iss_done = done; iss_dest = dest;
    iss_data = data; iss_cur_pc = cpc; iss_mis_pc = mpc; iss_pb_tk = pbtk;
    iss_opt = 6'h2a;
  endtask

  // Two busy normals (tags 1,2) completed together, then observed at commit.
  task automatic dual_case(input logic [4:0] da, input logic [4:0] db);
    do_reset();
    issue(2'd0, 1'b0, da, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    issue(2'd0, 1'b0, db, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    clr();
    cdb_valid = 2'b11; cdb_src = 8'h21; cdb_val = {32'h42, 32'h31};
    cyc();
    clr();
    cyc();
`ifdef ROB_DUAL_COMMIT_EN
    if (da == db) begin
      chk("dual_same_wr0_ena", wr0_ena, 1'b0);
    end else begin
      chk("dual_wr0_ena", wr0_ena, 1'b1);
      chk("dual_wr0_rd",  wr0_rd,  da);
      chk("dual_wr0_val", wr0_val, 32'h31);
    end
    chk("dual_wr1_ena", wr1_ena, 1'b1);
    chk("dual_wr1_rd",  wr1_rd,  db);
    chk("dual_wr1_val", wr1_val, 32'h42);
    chk("dual_wr1_idx", wr1_idx, 4'd2);
    chk("dual_count",   dut.count_q, 5'd0);
`else
    chk("single_c1_wr0_ena", wr0_ena, 1'b1);
    chk("single_c1_wr0_rd",  wr0_rd,  da);
    chk("single_c1_wr0_val", wr0_val, 32'h31);
    chk("single_c1_wr1_ena", wr1_ena, 1'b0);
    cyc();
    chk("single_c2_wr0_ena", wr0_ena, 1'b1);
    chk("single_c2_wr0_rd",  wr0_rd,  db);
    chk("single_c2_wr0_val", wr0_val, 32'h42);
    chk("single_c2_wr0_idx", wr0_idx, 4'd2);
    chk("single_c2_wr1_ena", wr1_ena, 1'b0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_iss_idx",   iss_idx, 4'd1);
    chk("rst_iss_ready", iss_ready, 1'b1);
    chk("rst_wr0_ena",   wr0_ena, 1'b0);
    chk("rst_rb_ena",    rb_ena, 1'b0);
    chk("rst_rb_pc",     rb_pc, 32'h0);
    chk("rst_fb_ena",    fb_ena, 1'b0);
    chk("rst_st_req",    st_req, 1'b0);
    chk("tag0_rdy",      src1_rdy, 1'b1);
    chk("tag0_val",      src1_val, 32'h0);

    // Three completed normals retire one per cycle
    issue(2'd0, 1'b1, 5'd5, 32'd1, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("t1_iss_idx", iss_idx, 4'd2);
    issue(2'd0, 1'b1, 5'd6, 32'd2, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("t1_c1_ena", wr0_ena, 1'b1);
    chk("t1_c1_rd",  wr0_rd, 5'd5);
    chk("t1_c1_val", wr0_val, 32'd1);
    chk("t1_c1_idx", wr0_idx, 4'd1);
    issue(2'd0, 1'b1, 5'd7, 32'd3, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("t1_c2_rd",  wr0_rd, 5'd6);
    chk("t1_c2_val", wr0_val, 32'd2);
    clr();
    cyc();
    chk("t1_c3_ena",   wr0_ena, 1'b1);
    chk("t1_c3_rd",    wr0_rd, 5'd7);
    chk("t1_c3_val",   wr0_val, 32'd3);
    chk("t1_c3_idx",   wr0_idx, 4'd3);
    chk("t1_count",    dut.count_q, 5'd0);
    cyc();
    chk("t1_idle_ena", wr0_ena, 1'b0);

    // Fill to the issue limit with busy entries
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      chk("t2_ready_fill", iss_ready, 1'b1);
      issue(2'd0, 1'b0, 5'(k), 32'h0, 32'h0, 32'h0, 1'b0);
      cyc();
    end
    clr();
    chk("t2_full_ready", iss_ready, 1'b0);
    chk("t2_full_idx",   iss_idx, 4'd12);
    cdb_valid = 2'b10; cdb_src = 8'h12; cdb_val = {32'hAA, 32'h55};
    src1_idx = 4'd1; src2_idx = 4'd2;
    #1;
    chk("t2_byp_rdy1", src1_rdy, 1'b1);
    chk("t2_byp_val1", src1_val, 32'hAA);
    chk("t2_inval_ch0", src2_rdy, 1'b0);
    cyc();
    cdb_valid = '0; cdb_src = '0; cdb_val = '0;
    #1;
    chk("t2_stored_rdy", src1_rdy, 1'b1);
    chk("t2_stored_val", src1_val, 32'hAA);
    chk("t2_ready_hold", iss_ready, 1'b0);
    cyc();
    chk("t2_commit_ena", wr0_ena, 1'b1);
    chk("t2_commit_rd",  wr0_rd, 5'd1);
    chk("t2_commit_val", wr0_val, 32'hAA);
    chk("t2_ready_back", iss_ready, 1'b1);

    // Tag sequence wraps 15 -> 1
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      chk("t3_iss_idx", iss_idx, (k == 16) ? 4'd1 : 4'(k));
      issue(2'd0, 1'b1, 5'd0, 32'(k), 32'h0, 32'h0, 1'b0);
      cyc();
    end
    clr();

    // Mispredicted branch: feedback, redirect, then flush
    do_reset();
    issue(2'd1, 1'b0, 5'd0, 32'h0, 32'h40, 32'h100, 1'b0);
    cyc();
    issue(2'd0, 1'b1, 5'd9, 32'h99, 32'h44, 32'h0, 1'b0);
    cyc();
    clr();
    cdb_valid = 2'b01; cdb_src = 8'h01; cdb_tk = 2'b01;
    cyc();
    clr();
    cyc();
    chk("t4_fb_ena", fb_ena, 1'b1);
    chk("t4_fb_tk",  fb_tk, 1'b1);
    chk("t4_fb_pc",  fb_pc, 32'h40);
    chk("t4_rb_ena", rb_ena, 1'b1);
    chk("t4_rb_pc",  rb_pc, 32'h100);
    chk("t4_ready_in_rb", iss_ready, 1'b0);
    cyc();
    chk("t4_rb_drop", rb_ena, 1'b0);
    chk("t4_count",   dut.count_q, 5'd0);
    chk("t4_head",    dut.head_q, 4'd1);
    chk("t4_tail",    iss_idx, 4'd1);
    chk("t4_no_wr_flush", wr0_ena, 1'b0);
    cyc();
    chk("t4_no_wr_after", wr0_ena, 1'b0);

    // jalr: link write and unconditional redirect to target with bit 0 cleared
    do_reset();
    issue(2'd3, 1'b1, 5'd1, 32'h301, 32'h200, 32'h0, 1'b0);
    cyc();
    clr();
    cyc();
    chk("t5_jalr_ena", wr0_ena, 1'b1);
    chk("t5_jalr_val", wr0_val, 32'h204);
    chk("t5_jalr_rb",  rb_ena, 1'b1);
    chk("t5_jalr_pc",  rb_pc, 32'h300);

    // Store at head waits for ack; duplicate CDB tag resolves to channel 1
    do_reset();
    issue(2'd2, 1'b0, 5'd0, 32'hDEAD, 32'h80, 32'h0, 1'b0);
    cyc();
    chk("t6_req_c1", st_req, 1'b1);
    issue(2'd0, 1'b0, 5'd2, 32'h0, 32'h84, 32'h0, 1'b0);
    cyc();
    chk("t6_req_c2", st_req, 1'b1);
    issue(2'd0, 1'b0, 5'd3, 32'h0, 32'h88, 32'h0, 1'b0);
    cyc();
    chk("t6_req_c3", st_req, 1'b1);
    issue(2'd0, 1'b0, 5'd4, 32'h0, 32'h8c, 32'h0, 1'b0);
    cyc();
    clr();
    rdy = 1'b0;
    #1;
    chk("t6_req_stall",   st_req, 1'b0);
    chk("t6_ready_stall", iss_ready, 1'b0);
    cyc();
    rdy = 1'b1;
    st_ack = 1'b1;
    cdb_valid = 2'b11; cdb_src = 8'h44; cdb_val = {32'h44, 32'h11};
    #1;
    chk("t6_req_ack",   st_req, 1'b1);
    chk("t6_count_pre", dut.count_q, 5'd4);
    cyc();
    clr();
    src1_idx = 4'd4;
    #1;
    chk("t6_no_wr",    wr0_ena, 1'b0);
    chk("t6_req_off",  st_req, 1'b0);
    chk("t6_count",    dut.count_q, 5'd3);
    chk("t6_head",     dut.head_q, 4'd2);
    chk("t6_dup_rdy",  src1_rdy, 1'b1);
    chk("t6_dup_val",  src1_val, 32'h44);

    // Two ready normals at head, distinct then identical rd
    dual_case(5'd3, 5'd4);
    dual_case(5'd3, 5'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
